// File: rtl/mac_vec.sv
// Multi-lane signed multiply-accumulate engine: LANES products per beat are summed into a
// wide accumulator over a configured beat count, then rounded, scaled and presented on a
// valid/ready port.
module mac_vec #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [5:0]            cfg_shift,
    input  logic                  cfg_sat,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_a,
    input  logic [LANES*DW-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [ACC_W-1:0]      out_acc,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HOLD} state_t;

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-DW){1'b1}}, {(DW-1){1'b0}}};

    state_t state, state_nxt;
    logic                    cfg_done;
    logic [LEN_W-1:0]        len_q;
    logic [5:0]              shift_q;
    logic                    sat_q;
    logic [LEN_W:0]          cnt, cnt_nxt, len_eff;
    logic [1:0]              fcnt, fcnt_nxt;
    logic                    accept, capture, release_out;
    logic signed [DW-1:0]    a_l [LANES];
    logic signed [DW-1:0]    b_l [LANES];
    logic signed [2*DW-1:0]  prod [LANES];
    logic                    prod_vld;
    logic signed [ACC_W-1:0] acc, lane_sum;
    logic signed [ACC_W:0]   acc_ext, rnd_add, rnd_val;
    logic [DW-1:0]           res_data;

    assign in_ready = cfg_done && (state == IDLE || state == RUN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign len_eff  = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_l[i] = in_a[i*DW +: DW];
            b_l[i] = in_b[i*DW +: DW];
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum = lane_sum + {{(ACC_W-2*DW){prod[i][2*DW-1]}}, prod[i]};
    end

    // Round half up, then shift; one extra bit keeps the rounding add from wrapping.
    always_comb begin
        acc_ext = {acc[ACC_W-1], acc};
        rnd_add = '0;
        if (shift_q != 6'd0)
            rnd_add = {{ACC_W{1'b0}}, 1'b1} << (shift_q - 6'd1);
        rnd_val = (acc_ext + rnd_add) >>> shift_q;
        if (sat_q && rnd_val > SAT_MAX)
            res_data = SAT_MAX[DW-1:0];
        else if (sat_q && rnd_val < SAT_MIN)
            res_data = SAT_MIN[DW-1:0];
        else
            res_data = rnd_val[DW-1:0];
    end

    // FLUSH lets both pipeline stages settle; the output stage captures on the exit edge.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        fcnt_nxt    = fcnt;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt   = {{LEN_W{1'b0}}, 1'b1};
                    fcnt_nxt  = 2'd0;
                    state_nxt = (len_eff == {{LEN_W{1'b0}}, 1'b1}) ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_nxt  = cnt + 1'b1;
                    fcnt_nxt = 2'd0;
                    if (cnt == len_eff - 1'b1)
                        state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                fcnt_nxt = fcnt + 2'd1;
                if (fcnt == 2'd2) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_vld <= 1'b0;
            for (int i = 0; i < LANES; i++)
                prod[i] <= '0;
        end else begin
            prod_vld <= accept;
            if (accept)
                for (int i = 0; i < LANES; i++)
                    prod[i] <= (2*DW)'(a_l[i]) * (2*DW)'(b_l[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            fcnt      <= '0;
            cfg_done  <= 1'b0;
            len_q     <= '0;
            shift_q   <= '0;
            sat_q     <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_acc   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            fcnt  <= fcnt_nxt;
            if (state == IDLE && cfg_en) begin
                len_q    <= cfg_len;
                shift_q  <= cfg_shift;
                sat_q    <= cfg_sat;
                cfg_done <= 1'b1;
            end
            if (release_out)
                acc <= '0;
            else if (prod_vld)
                acc <= acc + lane_sum;
            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= res_data;
                out_acc   <= acc;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_vec.sv
// Randomised scoreboard bench for mac_vec: stimulus pushes expected results computed with
// plain arithmetic; a monitor compares every cycle the DUT holds a result.
module tb_mac_vec;

    logic        clk;
    logic        rst_n;
    logic        cfg_en;
    logic [7:0]  cfg_len;
    logic [5:0]  cfg_shift;
    logic        cfg_sat;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [39:0] out_acc;
    logic        busy;

    typedef struct {
        logic [39:0] acc;
        logic [15:0] data;
        int          acc_cyc;
    } exp_t;

    exp_t               exp_q[$];
    int                 checks = 0;
    int                 failures = 0;
    int                 cyc = 0;
    int                 ready_mode = 2;
    int                 cur_shift = 0;
    bit                 cur_sat = 0;
    bit                 front_seen = 0;
    logic signed [63:0] model_sum = 0;

    mac_vec dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_en(cfg_en), .cfg_len(cfg_len), .cfg_shift(cfg_shift), .cfg_sat(cfg_sat),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_acc(out_acc), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic [15:0] refData(input logic signed [63:0] a40, input int s, input bit sat);
        logic signed [63:0] r;
        r = a40;
        if (s > 0) r = r + (64'sd1 <<< (s - 1));
        r = r >>> s;
        if (sat && r > 64'sd32767) return 16'h7FFF;
        if (sat && r < -64'sd32768) return 16'h8000;
        return r[15:0];
    endfunction

    // Sends one beat, updates the reference sum, and queues the result on the last beat.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input bit last, input int gap);
        int t = 0;
        exp_t e;
        logic signed [63:0] w;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) begin
            timeoutFail("beat_accept");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            model_sum = model_sum + longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
        if (last) begin
            w = {{24{model_sum[39]}}, model_sum[39:0]};
            e.acc = model_sum[39:0];
            e.data = refData(w, cur_shift, cur_sat);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            model_sum = 0;
        end
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic applyConfig(input logic [7:0] len, input int shift, input bit sat);
        int t = 0;
        while ((busy || out_valid) && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        if (busy || out_valid) timeoutFail("cfg_wait_idle");
        cfg_len = len;
        cfg_shift = 6'(shift);
        cfg_sat = sat;
        cfg_en = 1'b1;
        @(posedge clk); #1;
        cfg_en = 1'b0;
        cur_shift = shift;
        cur_sat = sat;
        checkOutput("cfg_in_ready", in_ready, 1);
    endtask

    task automatic waitDrain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        if (exp_q.size() != 0) begin
            timeoutFail("result_drain");
            exp_q.delete();
            front_seen = 0;
        end
    endtask

    function automatic logic [63:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    // Output-ready driver: random, held low, or held high.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'($urandom_range(0, 1));
                1: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: every cycle a result is held, it must match the queue front.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output out_acc=0x%0h out_data=0x%0h at cycle %0d", out_acc, out_data, cyc);
            end else begin
                if (!front_seen) begin
                    checkOutput("latency", 64'(cyc - exp_q[0].acc_cyc), 3);
                    front_seen = 1;
                end
                checkOutput("out_acc", out_acc, exp_q[0].acc);
                checkOutput("out_data", out_data, exp_q[0].data);
                checkOutput("hold_in_ready", in_ready, 0);
                checkOutput("hold_busy", busy, 1);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    front_seen = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] a, b;
        int len;
        rst_n = 1'b0;
        cfg_en = 1'b0;
        cfg_len = '0;
        cfg_shift = '0;
        cfg_sat = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_acc", out_acc, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] unconfigured input");
        in_valid = 1'b1;
        in_a = pack4(1, 1, 1, 1);
        in_b = pack4(1, 1, 1, 1);
        repeat (4) begin
            checkOutput("unconf_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("unconf_out_valid", out_valid, 0);
        checkOutput("unconf_busy", busy, 0);

        $display("[TB] basic dot product");
        ready_mode = 2;
        applyConfig(8'd2, 0, 0);
        applyStimulus(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0, 0);
        applyStimulus(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1, 0);
        waitDrain();

        $display("[TB] saturation and truncation");
        applyConfig(8'd1, 0, 1);
        applyStimulus(pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767), 1, 0);
        waitDrain();
        applyConfig(8'd1, 0, 0);
        applyStimulus(pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767), 1, 0);
        waitDrain();

        $display("[TB] rounding shift");
        applyConfig(8'd1, 1, 0);
        applyStimulus(pack4(3, 0, 0, 0), pack4(1, 0, 0, 0), 1, 0);
        waitDrain();
        applyStimulus(pack4(-3, 0, 0, 0), pack4(1, 0, 0, 0), 1, 0);
        waitDrain();

        $display("[TB] backpressure and gaps");
        ready_mode = 1;
        applyConfig(8'd3, 0, 0);
        applyStimulus(pack4(10, -20, 30, -40), pack4(7, 7, 7, 7), 0, 1);
        applyStimulus(pack4(100, 200, -300, 400), pack4(-2, 3, 4, 5), 0, 1);
        applyStimulus(pack4(-1, -1, -1, -1), pack4(9, 9, 9, 9), 1, 0);
        for (int t = 0; t < 20 && !out_valid; t++) begin
            @(posedge clk); #1;
        end
        repeat (5) begin
            @(posedge clk); #1;
        end
        checkOutput("bp_still_held", out_valid, 1);
        ready_mode = 2;
        waitDrain();
        for (int k = 0; k < 3; k++)
            applyStimulus({16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)},
                          {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)}, k == 2, 0);
        waitDrain();

        $display("[TB] full length with ignored config");
        applyConfig(8'd0, 0, 0);
        for (int k = 0; k < 256; k++) begin
            applyStimulus(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), k == 255, 0);
            if (k == 100) begin
                cfg_len = 8'd5;
                cfg_shift = 6'd3;
                cfg_en = 1'b1;
                @(posedge clk); #1;
                cfg_en = 1'b0;
            end
        end
        waitDrain();

        $display("[TB] randomised dot products");
        ready_mode = 0;
        for (int n = 0; n < 12; n++) begin
            len = $urandom_range(1, 6);
            applyConfig(8'(len), $urandom_range(0, 24), 1'($urandom_range(0, 1)));
            for (int k = 0; k < len; k++) begin
                a = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
                b = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
                if (n % 3 == 0) begin
                    a = a & 64'h00FF_00FF_00FF_00FF;
                    b = b & 64'h003F_003F_003F_003F;
                end
                applyStimulus(a, b, k == len - 1, $urandom_range(0, 2));
            end
        end
        waitDrain();
        ready_mode = 2;

        $display("[TB] reset mid-run");
        applyConfig(8'd4, 0, 0);
        applyStimulus(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 0, 0);
        applyStimulus(pack4(6, 6, 6, 6), pack4(6, 6, 6, 6), 0, 0);
        rst_n = 1'b0;
        model_sum = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_out_acc", out_acc, 0);
        checkOutput("mid_rst_out_data", out_data, 0);
        checkOutput("mid_rst_busy", busy, 0);
        in_valid = 1'b1;
        repeat (3) begin
            checkOutput("mid_rst_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("mid_rst_no_output", out_valid, 0);
        applyConfig(8'd2, 2, 1);
        applyStimulus(pack4(-7, 8, -9, 10), pack4(3, -3, 3, -3), 0, 0);
        applyStimulus(pack4(1000, 2000, 3000, 4000), pack4(11, 12, 13, 14), 1, 0);
        waitDrain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
